// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle shift/rotate unit.
// Shifts an operand left or right by 0..2^AMT_W-1 positions, one bit per clock.
// Modes: logical, rotate, rotate-through-carry and arithmetic.
// start/busy/done handshake. dout and cout stay registered until the next start.
module shift_unit_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] din,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_LOGIC  = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_RCARRY = 2'b10,
    MODE_ARITH  = 2'b11
  } mode_t;

  state_t           state;
  mode_t            mode_q;
  logic             dir_q;
  logic [AMT_W-1:0] count;

  logic [WIDTH-1:0] step_dout;
  logic             step_cout;

  // Next value of {cout, dout} after one 1-bit step in the latched direction and mode.
  always_comb begin
    // NOTE: both outputs get a default first, so no path through the case can infer a latch.
    step_dout = dout;
    step_cout = cout;
    if (!dir_q) begin
      // Every right step moves the bit leaving dout[0] into the carry.
      step_cout = dout[0];
      unique case (mode_q)
        MODE_LOGIC:  step_dout = {1'b0,        dout[WIDTH-1:1]};
        MODE_ROTATE: step_dout = {dout[0],     dout[WIDTH-1:1]};
        MODE_RCARRY: step_dout = {cout,        dout[WIDTH-1:1]};
        MODE_ARITH:  step_dout = {dout[WIDTH-1], dout[WIDTH-1:1]};
        default:     step_dout = dout;
      endcase
    end else begin
      // Every left step moves the bit leaving dout[WIDTH-1] into the carry.
      step_cout = dout[WIDTH-1];
      unique case (mode_q)
        MODE_LOGIC:  step_dout = {dout[WIDTH-2:0], 1'b0};
        MODE_ROTATE: step_dout = {dout[WIDTH-2:0], dout[WIDTH-1]};
        MODE_RCARRY: step_dout = {dout[WIDTH-2:0], cout};
        MODE_ARITH:  step_dout = {dout[WIDTH-2:0], 1'b0};
        default:     step_dout = dout;
      endcase
    end
  end

  // Control FSM with registered busy/done, plus the result and carry registers.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments, so every register samples pre-edge values.
    if (!rst_n) begin
      // A reset during SHIFT throws away the partial result.
      state  <= IDLE;
      mode_q <= MODE_LOGIC;
      dir_q  <= 1'b0;
      count  <= '0;
      dout   <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dout   <= din;
            cout   <= cin;
            dir_q  <= dir;
            mode_q <= mode_t'(mode);
            count  <= amount;
            if (amount == '0) begin
              // A zero amount goes straight to DONE and returns the operand unchanged.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          dout  <= step_dout;
          cout  <= step_cout;
          count <= count - AMT_W'(1);
          // The step that takes count to zero also leaves SHIFT.
          if (count == AMT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
